// File: rtl/dit_fft_8_pkg.sv
// Shared constants, FSM encoding, bit-reverse table and number-format helpers for dit_fft_8.
package dit_fft_8_pkg;

    localparam int W    = 16;   // port sample width (sign-magnitude)
    localparam int FRAC = 8;    // fraction bits
    localparam int TW   = 181;  // 0.7071 in Q8

    // Work width: 15-bit magnitude, sign, and three bits for the 8x growth of a full-scale sum.
    localparam int IW   = 19;

    typedef logic signed [IW-1:0] work_t;
    typedef logic        [W-1:0]  sample_t;

    typedef enum logic [2:0] {IDLE, LOAD, S1, S2, S3, DONE} state_t;
    typedef enum logic [1:0] {TW_W0, TW_W1, TW_W2, TW_W3} tw_sel_t;

    // Work slot i is loaded from sample BIT_REV[i].
    localparam logic [2:0] BIT_REV [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    // Sign-magnitude to two's complement; -0 maps to 0.
    function automatic work_t sm_to_tc(input sample_t sm);
        work_t mag;
        mag = work_t'({{(IW-W+1){1'b0}}, sm[W-2:0]});
        return sm[W-1] ? -mag : mag;
    endfunction

    // Two's complement to sign-magnitude, saturating the magnitude at 0x7FFF.
    // A negative value always has a non-zero magnitude, so -0 cannot be produced.
    function automatic sample_t tc_to_sm(input work_t v);
        logic [IW-1:0] mag;
        mag = v[IW-1] ? -v : v;
        if (|mag[IW-1:W-1])
            return {v[IW-1], {(W-1){1'b1}}};
        return {v[IW-1], mag[W-2:0]};
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Radix-2 butterfly: A' = A + W*B, B' = A - W*B, with W chosen from W0..W3 of the 8-point set.
module fft_butterfly
    import dit_fft_8_pkg::*;
(
    input  work_t   a_r,
    input  work_t   a_i,
    input  work_t   b_r,
    input  work_t   b_i,
    input  tw_sel_t tw_sel,
    output work_t   ap_r,
    output work_t   ap_i,
    output work_t   bp_r,
    output work_t   bp_i
);

    localparam int              PW   = IW + 9;
    localparam logic signed [8:0] TW_S = 9'(TW);

    work_t p_r, p_i, wb_r, wb_i;

    // B scaled by 0.7071, truncated toward minus infinity by the arithmetic shift.
    assign p_r = work_t'((PW'(b_r) * PW'(TW_S)) >>> FRAC);
    assign p_i = work_t'((PW'(b_i) * PW'(TW_S)) >>> FRAC);

    // Rotate B by the selected twiddle; W0 and W2 (-j) are exact swaps/negations.
    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        wb_r = b_r;
        wb_i = b_i;
        case (tw_sel)
            TW_W1:   begin wb_r = p_r + p_i; wb_i = p_i - p_r;    end
            TW_W2:   begin wb_r = b_i;       wb_i = -b_r;         end
            TW_W3:   begin wb_r = p_i - p_r; wb_i = -(p_r + p_i); end
            default: ;
        endcase
    end

    assign ap_r = a_r + wb_r;
    assign ap_i = a_i + wb_i;
    assign bp_r = a_r - wb_r;
    assign bp_i = a_i - wb_i;

endmodule

// File: rtl/dit_fft_8.sv
// 8-point radix-2 DIT FFT: parallel load, one butterfly stage per clock, parallel result with ready.
module dit_fft_8
    import dit_fft_8_pkg::*;
(
    input  logic         clk,
    input  logic         RST_N,
    input  logic         write,
    input  logic         start,
    input  logic [W-1:0] in0_r, in1_r, in2_r, in3_r, in4_r, in5_r, in6_r, in7_r,
    input  logic [W-1:0] in0_i, in1_i, in2_i, in3_i, in4_i, in5_i, in6_i, in7_i,
    output logic [W-1:0] out0_r, out1_r, out2_r, out3_r, out4_r, out5_r, out6_r, out7_r,
    output logic [W-1:0] out0_i, out1_i, out2_i, out3_i, out4_i, out5_i, out6_i, out7_i,
    output logic         ready
);

    state_t     state, state_nxt;
    logic       start_q, start_edge;
    logic       launch, take_write, run_stage, publish;
    sample_t    in_r [8], in_i [8], smp_r [8], smp_i [8], res_r [8], res_i [8];
    work_t      work_r [8], work_i [8], stage_r [8], stage_i [8];
    logic [2:0] idx_a [4], idx_b [4];
    tw_sel_t    tw [4];
    work_t      ap_r [4], ap_i [4], bp_r [4], bp_i [4];

    assign in_r = '{in0_r, in1_r, in2_r, in3_r, in4_r, in5_r, in6_r, in7_r};
    assign in_i = '{in0_i, in1_i, in2_i, in3_i, in4_i, in5_i, in6_i, in7_i};

    assign {out0_r, out1_r, out2_r, out3_r} = {res_r[0], res_r[1], res_r[2], res_r[3]};
    assign {out4_r, out5_r, out6_r, out7_r} = {res_r[4], res_r[5], res_r[6], res_r[7]};
    assign {out0_i, out1_i, out2_i, out3_i} = {res_i[0], res_i[1], res_i[2], res_i[3]};
    assign {out4_i, out5_i, out6_i, out7_i} = {res_i[4], res_i[5], res_i[6], res_i[7]};

    assign start_edge = start & ~start_q;

    // Registered copy of start for rising-edge detection.
    always_ff @(posedge clk or posedge RST_N) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (RST_N) start_q <= 1'b0;
        else       start_q <= start;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge RST_N) begin
        if (RST_N) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state: a start edge launches from IDLE/DONE, busy states advance every clock.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start_edge) state_nxt = LOAD;
            LOAD:       state_nxt = S1;
            S1:         state_nxt = S2;
            S2:         state_nxt = S3;
            S3:         state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // FSM outputs: datapath controls decoded from the current state.
    always_comb begin
        take_write = 1'b0;
        launch     = 1'b0;
        run_stage  = 1'b0;
        publish    = 1'b0;
        case (state)
            IDLE, DONE:   begin take_write = write; launch = start_edge; end
            LOAD, S1, S2: run_stage = 1'b1;
            S3:           publish   = 1'b1;
            default:      ;
        endcase
    end

    // Operand routing for the four shared butterflies: span 1 in LOAD, span 2 in S1, span 4 in S2.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx_a[k] = 3'(2 * k);
            idx_b[k] = 3'(2 * k + 1);
            tw[k]    = TW_W0;
        end
        case (state)
            S1: for (int k = 0; k < 4; k++) begin
                idx_a[k] = {k[1], 1'b0, k[0]};
                idx_b[k] = {k[1], 1'b1, k[0]};
                tw[k]    = k[0] ? TW_W2 : TW_W0;
            end
            S2: for (int k = 0; k < 4; k++) begin
                idx_a[k] = {1'b0, k[1:0]};
                idx_b[k] = {1'b1, k[1:0]};
                tw[k]    = tw_sel_t'(k[1:0]);
            end
            default: ;
        endcase
    end

    for (genvar k = 0; k < 4; k++) begin : g_bf
        fft_butterfly u_bf (
            .a_r    (work_r[idx_a[k]]),
            .a_i    (work_i[idx_a[k]]),
            .b_r    (work_r[idx_b[k]]),
            .b_i    (work_i[idx_b[k]]),
            .tw_sel (tw[k]),
            .ap_r   (ap_r[k]),
            .ap_i   (ap_i[k]),
            .bp_r   (bp_r[k]),
            .bp_i   (bp_i[k])
        );
    end

    // Next contents of the work array after the current stage's butterflies.
    always_comb begin
        stage_r = work_r;
        stage_i = work_i;
        for (int k = 0; k < 4; k++) begin
            stage_r[idx_a[k]] = ap_r[k];
            stage_i[idx_a[k]] = ap_i[k];
            stage_r[idx_b[k]] = bp_r[k];
            stage_i[idx_b[k]] = bp_i[k];
        end
    end

    // Sample registers: captured by write while idle or done.
    always_ff @(posedge clk or posedge RST_N) begin
        // NOTE: these arrays are a few flops, not RAM, and must read zero after reset, so they are reset.
        if (RST_N) begin
            smp_r <= '{default: '0};
            smp_i <= '{default: '0};
        end else if (take_write) begin
            smp_r <= in_r;
            smp_i <= in_i;
        end
    end

    // Work registers: bit-reversed load on launch (bypassing a same-edge write), then one stage per clock.
    always_ff @(posedge clk or posedge RST_N) begin
        if (RST_N) begin
            work_r <= '{default: '0};
            work_i <= '{default: '0};
        end else if (launch) begin
            for (int i = 0; i < 8; i++) begin
                work_r[i] <= sm_to_tc(take_write ? in_r[BIT_REV[i]] : smp_r[BIT_REV[i]]);
                work_i[i] <= sm_to_tc(take_write ? in_i[BIT_REV[i]] : smp_i[BIT_REV[i]]);
            end
        end else if (run_stage) begin
            work_r <= stage_r;
            work_i <= stage_i;
        end
    end

    // Result registers: converted back to sign-magnitude when the last stage is complete.
    always_ff @(posedge clk or posedge RST_N) begin
        if (RST_N) begin
            res_r <= '{default: '0};
            res_i <= '{default: '0};
        end else if (publish) begin
            for (int i = 0; i < 8; i++) begin
                res_r[i] <= tc_to_sm(work_r[i]);
                res_i[i] <= tc_to_sm(work_i[i]);
            end
        end
    end

    // Ready: set on publish, cleared by an accepted write or a launch.
    always_ff @(posedge clk or posedge RST_N) begin
        if (RST_N)                    ready <= 1'b0;
        else if (publish)             ready <= 1'b1;
        else if (launch || take_write) ready <= 1'b0;
    end

endmodule

// File: tb/tb_dit_fft_8.sv
// Self-checking bench for dit_fft_8: directed cases plus random frames against a direct-DFT model.
module tb_dit_fft_8;

    logic        clk = 1'b0;
    logic        RST_N, write, start;
    logic [15:0] in_r [8], in_i [8], out_r [8], out_i [8];
    logic        ready;

    int n_checks = 0;
    int n_errors = 0;

    // Samples the DUT is expected to be transforming, and the model result.
    logic [15:0] x_r [8], x_i [8];
    logic [15:0] y_r [8], y_i [8];
    int          exp_r [8], exp_i [8];

    // e^{-j*2*pi*m/8} scaled by 256, with 0.7071 quantised to 181/256.
    int tw_c [8] = '{256, 181, 0, -181, -256, -181, 0, 181};
    int tw_s [8] = '{0, -181, -256, -181, 0, 181, 256, 181};

    always #5 clk = ~clk;

    dit_fft_8 dut (
        .clk(clk), .RST_N(RST_N), .write(write), .start(start),
        .in0_r(in_r[0]), .in1_r(in_r[1]), .in2_r(in_r[2]), .in3_r(in_r[3]),
        .in4_r(in_r[4]), .in5_r(in_r[5]), .in6_r(in_r[6]), .in7_r(in_r[7]),
        .in0_i(in_i[0]), .in1_i(in_i[1]), .in2_i(in_i[2]), .in3_i(in_i[3]),
        .in4_i(in_i[4]), .in5_i(in_i[5]), .in6_i(in_i[6]), .in7_i(in_i[7]),
        .out0_r(out_r[0]), .out1_r(out_r[1]), .out2_r(out_r[2]), .out3_r(out_r[3]),
        .out4_r(out_r[4]), .out5_r(out_r[5]), .out6_r(out_r[6]), .out7_r(out_r[7]),
        .out0_i(out_i[0]), .out1_i(out_i[1]), .out2_i(out_i[2]), .out3_i(out_i[3]),
        .out4_i(out_i[4]), .out5_i(out_i[5]), .out6_i(out_i[6]), .out7_i(out_i[7]),
        .ready(ready)
    );

    task automatic check(input string tag, input int got, input int exp, input int tol = 0);
        int diff;
        n_checks++;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d",
                     tag, got, got, exp, exp, tol);
        end
    endtask

    function automatic int sm_dec(input logic [15:0] v);
        int mag;
        mag = int'(v[14:0]);
        return v[15] ? -mag : mag;
    endfunction

    function automatic int clip(input int v);
        if (v > 32767)  return 32767;
        if (v < -32767) return -32767;
        return v;
    endfunction

    function automatic logic [15:0] sm_enc(input int v);
        int mag;
        mag = clip(v);
        if (mag < 0) mag = -mag;
        if (mag == 0) return 16'h0000;
        return {(v < 0) ? 1'b1 : 1'b0, mag[14:0]};
    endfunction

    function automatic logic [15:0] rand_sample();
        logic [14:0] mag;
        logic        sgn;
        mag = 15'($urandom_range(0, 'h3FFF));
        if ($urandom_range(0, 15) == 0) mag = '0;
        sgn = 1'($urandom_range(0, 1));
        return {sgn, mag};
    endfunction

    // Direct 8-point DFT of x, rounded to the nearest LSB and clipped to the port range.
    task automatic compute_model();
        longint acc_r, acc_i;
        int     m, xr, xi;
        for (int k = 0; k < 8; k++) begin
            acc_r = 0;
            acc_i = 0;
            for (int n = 0; n < 8; n++) begin
                m  = (k * n) % 8;
                xr = sm_dec(x_r[n]);
                xi = sm_dec(x_i[n]);
                acc_r += longint'(xr) * tw_c[m] - longint'(xi) * tw_s[m];
                acc_i += longint'(xr) * tw_s[m] + longint'(xi) * tw_c[m];
            end
            exp_r[k] = clip(int'((acc_r + 128) >>> 8));
            exp_i[k] = clip(int'((acc_i + 128) >>> 8));
        end
    endtask

    // Even bins are exact; odd bins carry the 0.7071 product truncation.
    task automatic compare_bins(input string tag);
        compute_model();
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                check($sformatf("%s_X%0d_r", tag, k), int'(out_r[k]), int'(sm_enc(exp_r[k])));
                check($sformatf("%s_X%0d_i", tag, k), int'(out_i[k]), int'(sm_enc(exp_i[k])));
            end else begin
                check($sformatf("%s_X%0d_r", tag, k), sm_dec(out_r[k]), exp_r[k], 2);
                check($sformatf("%s_X%0d_i", tag, k), sm_dec(out_i[k]), exp_i[k], 2);
                check($sformatf("%s_X%0d_negzero", tag, k),
                      int'(out_r[k] == 16'h8000 || out_i[k] == 16'h8000), 0);
            end
        end
    endtask

    task automatic drive_inputs();
        for (int n = 0; n < 8; n++) begin
            in_r[n] = x_r[n];
            in_i[n] = x_i[n];
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic load_samples();
        drive_inputs();
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic start_and_wait(input bit with_write, input string tag);
        int lat;
        if (with_write) begin
            drive_inputs();
            write = 1'b1;
        end
        start = 1'b1;
        @(negedge clk);
        write = 1'b0;
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ready) begin
                lat = c;
                break;
            end
        end
        check({tag, "_latency"}, lat, 4);
    endtask

    task automatic random_frame();
        for (int n = 0; n < 8; n++) begin
            x_r[n] = rand_sample();
            x_i[n] = rand_sample();
        end
    endtask

    task automatic clear_frame();
        for (int n = 0; n < 8; n++) begin
            x_r[n] = 16'h0000;
            x_i[n] = 16'h0000;
        end
    endtask

    initial begin
        int ramp [8] = '{5, 6, 4, 4, 7, 6, 7, 9};
        int rises;
        logic prev;

        RST_N = 1'b1;
        write = 1'b0;
        start = 1'b0;
        clear_frame();
        drive_inputs();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("reset_out%0d_r", k), int'(out_r[k]), 0);
            check($sformatf("reset_out%0d_i", k), int'(out_i[k]), 0);
        end
        check("reset_ready", int'(ready), 0);
        RST_N = 1'b0;
        @(negedge clk);

        // Impulse at x[0].
        x_r[0] = 16'h0100;
        load_samples();
        start_and_wait(1'b0, "impulse");
        compare_bins("impulse");
        check("impulse_X3_r", int'(out_r[3]), 'h0100);

        // Real ramp, loaded by a write on the same edge as the start.
        clear_frame();
        for (int n = 0; n < 8; n++) x_r[n] = 16'(ramp[n] << 8);
        start_and_wait(1'b1, "ramp");
        compare_bins("ramp");
        check("ramp_X0_r", int'(out_r[0]), 'h3000);
        check("ramp_X4_r", int'(out_r[4]), 'h8200);
        check("ramp_X2_r", int'(out_r[2]), 'h0100);
        check("ramp_X2_i", int'(out_i[2]), 'h0100);
        check("ramp_X6_r", int'(out_r[6]), 'h0100);
        check("ramp_X6_i", int'(out_i[6]), 'h8100);
        check("ramp_X1_r", sm_dec(out_r[1]), 393, 2);
        check("ramp_X1_i", sm_dec(out_i[1]), 1673, 2);
        check("ramp_X7_conj", sm_dec(out_i[7]), -1673, 2);

        // Full-scale DC saturates X0.
        for (int n = 0; n < 8; n++) x_r[n] = 16'h7F00;
        load_samples();
        start_and_wait(1'b0, "sat");
        compare_bins("sat");
        check("sat_X0_r", int'(out_r[0]), 'h7FFF);
        check("sat_X4_r", int'(out_r[4]), 'h0000);

        // Negative impulse at x[1].
        clear_frame();
        x_r[1] = 16'h8100;
        load_samples();
        start_and_wait(1'b0, "neg");
        compare_bins("neg");
        check("neg_X0_r", int'(out_r[0]), 'h8100);
        check("neg_X4_r", int'(out_r[4]), 'h0100);
        check("neg_X2_i", int'(out_i[2]), 'h0100);
        check("neg_X1_r", sm_dec(out_r[1]), -181, 1);
        check("neg_X1_i", sm_dec(out_i[1]), 181, 1);

        // Random frames, alternating separate and same-edge loading.
        for (int t = 0; t < 20; t++) begin
            random_frame();
            if (t % 2 == 0) begin
                load_samples();
                start_and_wait(1'b0, $sformatf("rnd%0d", t));
            end else begin
                start_and_wait(1'b1, $sformatf("rnd%0d", t));
            end
            compare_bins($sformatf("rnd%0d", t));
        end

        // start held high for 20 cycles launches exactly one transform.
        random_frame();
        load_samples();
        check("hold_write_clears_ready", int'(ready), 0);
        start = 1'b1;
        rises = 0;
        prev  = ready;
        for (int c = 0; c < 28; c++) begin
            if (c == 20) start = 1'b0;
            @(negedge clk);
            if (ready && !prev) rises++;
            prev = ready;
        end
        check("hold_one_transform", rises, 1);
        compare_bins("hold");

        // Write during S1 is ignored; a start pulse during S2 is dropped.
        random_frame();
        load_samples();
        start = 1'b1;
        @(negedge clk);                     // start edge sampled: LOAD
        start = 1'b0;
        @(negedge clk);                     // S1
        for (int n = 0; n < 8; n++) begin
            y_r[n] = rand_sample();
            y_i[n] = rand_sample();
            in_r[n] = y_r[n];
            in_i[n] = y_i[n];
        end
        write = 1'b1;
        @(negedge clk);                     // S2
        write = 1'b0;
        start = 1'b1;
        @(negedge clk);                     // S3
        start = 1'b0;
        @(negedge clk);                     // DONE
        check("busy_ready", int'(ready), 1);
        repeat (6) @(negedge clk);
        check("busy_start_dropped", int'(ready), 1);
        compare_bins("busy");
        start_and_wait(1'b0, "rerun");
        compare_bins("rerun");

        // Write in DONE clears ready and leaves the outputs alone.
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        check("done_write_ready", int'(ready), 0);
        compare_bins("done_write_hold");
        for (int n = 0; n < 8; n++) begin
            x_r[n] = y_r[n];
            x_i[n] = y_i[n];
        end
        start_and_wait(1'b0, "after_done_write");
        compare_bins("after_done_write");

        // Asynchronous reset in the middle of S2.
        random_frame();
        load_samples();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 RST_N = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("midrst_out%0d_r", k), int'(out_r[k]), 0);
            check($sformatf("midrst_out%0d_i", k), int'(out_i[k]), 0);
        end
        check("midrst_ready", int'(ready), 0);
        @(negedge clk);
        RST_N = 1'b0;
        repeat (10) @(negedge clk);
        check("postrst_no_run_ready", int'(ready), 0);
        check("postrst_no_run_out0", int'(out_r[0]), 0);

        // After reset the sample registers are clear, so a transform yields zeros.
        clear_frame();
        start_and_wait(1'b0, "postrst");
        compare_bins("postrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

endmodule
